// File: rtl/phase_sequencer_if.sv
// Control/status bundle between board/debug logic and the phase sequencer.
interface phase_sequencer_if #(
  parameter int IC_WIDTH = 32
);
  logic                run;
  logic                step;
  logic                stop;
  logic                mem_busy;
  logic [31:0]         pc;
  logic                bp_en;
  logic [31:0]         bp_addr;
  logic [3:0]          cstate;
  logic                running;
  logic                bp_hit;
  logic [IC_WIDTH-1:0] icount;

  modport master (
    output run, step, stop, mem_busy, pc, bp_en, bp_addr,
    input  cstate, running, bp_hit, icount
  );

  modport slave (
    input  run, step, stop, mem_busy, pc, bp_en, bp_addr,
    output cstate, running, bp_hit, icount
  );
endinterface

// File: rtl/phase_sequencer.sv
// Multicycle core phase sequencer: one-hot F/D/E/W phases with run/step/stop,
// memory stalls, PC breakpoint and retired-instruction counter.
module phase_sequencer #(
  parameter int IC_WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  phase_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_F,
    ST_D,
    ST_E,
    ST_W
  } state_t;

  state_t              state, state_nxt;
  logic                single, single_nxt;
  logic                first, first_nxt;
  logic                stop_req, stop_req_nxt;
  logic                bp_hit, bp_hit_nxt;
  logic [IC_WIDTH-1:0] icount, icount_nxt;
  logic                bp_match;

  // The first fetch after leaving IDLE never breaks, so resuming executes bp_addr.
  assign bp_match = bus.bp_en && (bus.pc == bus.bp_addr) && !first;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      single   <= 1'b0;
      first    <= 1'b0;
      stop_req <= 1'b0;
      bp_hit   <= 1'b0;
      icount   <= '0;
    end else begin
      state    <= state_nxt;
      single   <= single_nxt;
      first    <= first_nxt;
      stop_req <= stop_req_nxt;
      bp_hit   <= bp_hit_nxt;
      icount   <= icount_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    single_nxt   = single;
    first_nxt    = first;
    bp_hit_nxt   = bp_hit;
    icount_nxt   = icount;
    stop_req_nxt = stop_req || ((state != ST_IDLE) && bus.stop);

    case (state)
      ST_IDLE: begin
        if (bus.run || bus.step) begin
          state_nxt  = ST_F;
          single_nxt = !bus.run;
          first_nxt  = 1'b1;
          bp_hit_nxt = 1'b0;
        end
      end
      ST_F: begin
        if (bp_match) begin
          state_nxt  = ST_IDLE;
          bp_hit_nxt = 1'b1;
        end else if (!bus.mem_busy) begin
          state_nxt = ST_D;
          first_nxt = 1'b0;
        end
      end
      ST_D: state_nxt = ST_E;
      ST_E: state_nxt = ST_W;
      ST_W: begin
        if (!bus.mem_busy) begin
          icount_nxt = icount + IC_WIDTH'(1);
          // A stop arriving in this very cycle counts alongside the registered request.
          if (single || stop_req || bus.stop || !bus.run) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_F;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if ((state != ST_IDLE) && (state_nxt == ST_IDLE)) begin
      stop_req_nxt = 1'b0;
    end
  end

  always_comb begin
    case (state)
      ST_F:    bus.cstate = 4'b0001;
      ST_D:    bus.cstate = 4'b0010;
      ST_E:    bus.cstate = 4'b0100;
      ST_W:    bus.cstate = 4'b1000;
      default: bus.cstate = 4'b0000;
    endcase
  end

  assign bus.running = (state != ST_IDLE);
  assign bus.bp_hit  = bp_hit;
  assign bus.icount  = icount;

endmodule
